// File: rtl/alu_pkg.sv
// Shared ALU definitions: control encodings and the multiply sequencer state type.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned shift-and-add multiplier that borrows the shared ALU adder.
// One ITER cycle per multiplier bit; the adder carry is recovered by an
// unsigned compare of the sum against the addend it started from.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ITER_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result
);

  mul_state_t         r_state;
  mul_state_t         w_state_nxt;
  logic [WIDTH-1:0]   r_acc_hi;
  logic [WIDTH-1:0]   r_acc_lo;
  logic [WIDTH-1:0]   r_mcand;
  logic [ITER_W-1:0]  r_cnt;
  logic               w_early;
  logic               w_carry;
  logic               w_accept;
  logic               w_last;

  // Next-state selection and ALU operand drive
  always_comb begin
    w_state_nxt = r_state;
    alu_a       = '0;
    alu_b       = '0;
    alu_ctrl    = ALU_ADD;
    w_early     = (op_a == '0) || (op_b == '0);
    w_carry     = (alu_result < r_acc_hi);
    w_accept    = 1'b0;
    w_last      = (r_cnt == ITER_W'(WIDTH - 1));
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = w_early ? DONE : ITER;
        end
      end
      ITER: begin
        alu_a = r_acc_hi;
        alu_b = r_acc_lo[0] ? r_mcand : '0;
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = w_early ? DONE : ITER;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, counter and shift-and-add accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_mcand  <= '0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_acc_hi <= '0;
        if (w_early) begin
          r_acc_lo <= '0;
        end else begin
          r_acc_lo <= op_b;
          r_mcand  <= op_a;
          r_cnt    <= '0;
        end
      end else if (r_state == ITER) begin
        // {carry, sum, acc_lo} >> 1
        r_acc_hi <= {w_carry, alu_result[WIDTH-1:1]};
        r_acc_lo <= {alu_result[0], r_acc_lo[WIDTH-1:1]};
        r_cnt    <= r_cnt + 1'b1;
      end
    end
  end

  assign busy       = (r_state == ITER);
  assign done       = (r_state == DONE);
  assign product_hi = r_acc_hi;
  assign product_lo = r_acc_lo;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq with the shared ALU modelled in the loop.
module tb_alu_mul_seq;

  localparam int W = 32;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic          busy;
  logic          done;
  logic [W-1:0]  product_hi;
  logic [W-1:0]  product_lo;
  logic [W-1:0]  alu_a;
  logic [W-1:0]  alu_b;
  logic [3:0]    alu_ctrl;
  logic [W-1:0]  alu_result;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] prod;
    int          lat;
    int          busy_cycles;
  } vec_t;

  vec_t vecs[7];

  alu_mul_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .product_hi(product_hi), .product_lo(product_lo),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result)
  );

  // Shared ALU
  always_comb begin
    case (alu_ctrl)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0010: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      default: alu_result = '0;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a falling edge: present a request for one cycle.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [63:0] prod);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    exp_q.push_back(prod);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for done, checking latency, busy duration and the product.
  // inj > 0 pulses a 7 x 9 request at that cycle, which must be ignored.
  task automatic wait_done(input string name, input int exp_lat, input int exp_busy, input int inj);
    int cycles;
    int bcnt;
    logic [63:0] e;
    cycles = 1;
    bcnt   = 0;
    while (!done && cycles < 100) begin
      if (busy) begin
        bcnt++;
        if (alu_ctrl !== 4'b0010) begin
          n_checks++;
          n_fail++;
          $display("FAIL %s alu_ctrl: got %b expected 0010", name, alu_ctrl);
        end
      end
      if (cycles == inj) begin
        start = 1'b1;
        op_a  = 32'd7;
        op_b  = 32'd9;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s timeout: no done after %0d cycles", name, cycles);
    end
    check({name, " latency"}, 64'(cycles), 64'(exp_lat));
    check({name, " busy_cycles"}, 64'(bcnt), 64'(exp_busy));
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
    check({name, " product"}, {product_hi, product_lo}, e);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;

    vecs[0] = '{32'd3,         32'd5,         64'h0000_0000_0000_000F, 33, 32};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 33, 32};
    vecs[2] = '{32'd0,         32'h1234,      64'h0,                   1,  0};
    vecs[3] = '{32'h8000_0000, 32'd2,         64'h0000_0001_0000_0000, 33, 32};
    vecs[4] = '{32'h1234,      32'd0,         64'h0,                   1,  0};
    vecs[5] = '{32'd1,         32'd1,         64'h1,                   33, 32};
    vecs[6] = '{32'hDEAD_BEEF, 32'h1000_0000, 64'h0DEA_DBEE_F000_0000, 33, 32};

    rst_n = 1'b0;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    repeat (2) @(negedge clk);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset product", {product_hi, product_lo}, 64'd0);
    check("reset alu_ab", {alu_a, alu_b}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table vectors
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      issue(vecs[i].a, vecs[i].b, vecs[i].prod);
      wait_done($sformatf("vec%0d", i), vecs[i].lat, vecs[i].busy_cycles, 0);
    end

    // Result holds after done
    @(negedge clk);
    check("hold after done", {product_hi, product_lo}, 64'h0DEA_DBEE_F000_0000);
    check("idle after done", 64'({busy, done}), 64'd0);

    // Random operands against a full-width multiply
    for (int i = 0; i < 4; i++) begin
      ra = $urandom_range(32'hFFFF_FFFF, 1);
      rb = $urandom_range(32'hFFFF_FFFF, 1);
      @(negedge clk);
      issue(ra, rb, 64'(ra) * 64'(rb));
      wait_done($sformatf("rand%0d", i), 33, 32, 0);
    end

    // Start mid-ITER is ignored; start in DONE is accepted back-to-back
    @(negedge clk);
    issue(32'd3, 32'd5, 64'd15);
    wait_done("ignore_mid", 33, 32, 8);
    issue(32'd7, 32'd9, 64'd63);
    wait_done("back2back", 33, 32, 0);

    // Asynchronous reset mid-ITER discards the operation
    @(negedge clk);
    issue(32'h0001_0000, 32'h0001_0000, 64'h0);
    repeat (9) @(negedge clk);
    check("pre-reset busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    void'(exp_q.pop_back());
    check("async reset busy", 64'(busy), 64'd0);
    check("async reset done", 64'(done), 64'd0);
    check("async reset product", {product_hi, product_lo}, 64'd0);
    check("async reset alu_ab", {alu_a, alu_b}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(32'd2, 32'd2, 64'd4);
    wait_done("after_reset", 33, 32, 0);

    check("queue drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Multi-cycle unsigned multiply sequencer that borrows the shared 32-bit ALU's ADD operation to compute a full 64-bit product by shift-and-add. It sits beside the ALU in the execute stage. The parent muxes the ALU inputs to this block while `busy` is high. It answers single-shot `start` requests with a `done` pulse and holds the result until the next accepted request.

## Interface
- `WIDTH`, 32, operand width; must equal the ALU data width.
- `ITER_W`, $clog2(WIDTH), iteration counter width.

- `clk` input 1: rising-edge clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: request pulse; sampled only in IDLE or DONE.
- `op_a` input WIDTH: multiplicand; sampled with `start`.
- `op_b` input WIDTH: multiplier; sampled with `start`.
- `busy` output 1: high exactly while in ITER.
- `done` output 1: one-cycle pulse, high while in DONE.
- `product_hi` output WIDTH: upper half of the product.
- `product_lo` output WIDTH: lower half of the product.
- `alu_a` output WIDTH: ALU operand A.
- `alu_b` output WIDTH: ALU operand B.
- `alu_ctrl` output 4: ALU control, constant ALU_ADD (4'b0010).
- `alu_result` input WIDTH: ALU result; combinational return from the shared ALU.

## Operation
- Registers: `acc_hi` (WIDTH bits), `acc_lo` (WIDTH bits), `mcand` (WIDTH bits), `cnt` (ITER_W bits), `state` (IDLE, ITER, DONE).
- Output mapping: `product_hi = acc_hi`, `product_lo = acc_lo`.
- Reset values: state = IDLE; all registers = 0; `busy` = 0, `done` = 0, both products = 0.
- IDLE or DONE with `start` = 1:
  - If `op_a` or `op_b` is 0 (early-out): `acc_hi` = 0, `acc_lo` = 0, go to DONE.
  - Otherwise: `acc_hi` = 0, `acc_lo` = `op_b`, `mcand` = `op_a`, `cnt` = 0, go to ITER.
- IDLE with `start` = 0: hold.
- DONE with `start` = 0: go to IDLE.
- ALU drive in ITER:
  - `alu_a` = `acc_hi`.
  - `alu_b` = `acc_lo[0] ? mcand : 0`.
  - `alu_ctrl` = ALU_ADD.
- ALU drive outside ITER: `alu_a` = 0, `alu_b` = 0, `alu_ctrl` = ALU_ADD.
- ITER step:
  - `sum = alu_result`.
  - Carry is recovered without an ALU carry-out: `carry = (sum < acc_hi)`, unsigned compare.
  - `{acc_hi, acc_lo} <= {carry, sum, acc_lo} >> 1`, giving WIDTH*2 bits.
  - `cnt` increments by 1.
  - At `cnt` = WIDTH-1, go to DONE after this step.
- `start` during ITER is ignored. No queueing; the requester waits for `done`.
- The product registers change during ITER. They are valid from the `done` cycle until the next accepted `start`.
- Arithmetic is unsigned only. Signed multiply is the caller's job (sign-fix outside).

## Timing
- `start` accepted at edge E0.
- Normal path:
  - ITER occupies cycles E0+1 through E0+WIDTH; `busy` is high for exactly WIDTH cycles.
  - DONE at E0+WIDTH+1, so latency is WIDTH+1 cycles (33 at default).
- Early-out path: DONE at E0+1, `busy` never asserts.
- Back-to-back: `start` in the DONE cycle is accepted. The next ITER begins on the following cycle with no IDLE bubble, and `done` does not repeat.
- Reset assertion at any time forces IDLE and all-zero outputs immediately (asynchronous). No partial result survives. Deassertion is synchronised by the parent.
- The ALU path is combinational within one cycle: `alu_a`/`alu_b` go out, `alu_result` comes back, and the registers update at the edge.

## Structure
- Shared package `alu_pkg`:
  - ALU control constants ALU_AND = 4'b0000, ALU_OR = 4'b0001, ALU_ADD = 4'b0010, ALU_SUB = 4'b0110.
  - `mul_state_t` enum {IDLE, ITER, DONE}.
- This block does not instantiate the ALU; the parent owns the ALU and the input mux.
- No sub-module. The FSM, counter and shift register form one always_ff plus one always_comb.
- The bench instantiates the ALU and wires it in the loop.

## Test plan
- 3 × 5:
  - `done` exactly 33 cycles after `start`.
  - `product_hi` = 0x00000000, `product_lo` = 0x0000000F.
  - `busy` high for 32 cycles.
- 0xFFFFFFFF × 0xFFFFFFFF (exercises carry recovery every step): `product_hi` = 0xFFFFFFFE, `product_lo` = 0x00000001.
- 0 × 0x1234 early-out: `done` 1 cycle after `start`, `busy` never high, product = 0.
- `start` (7 × 9) pulsed mid-ITER of 3 × 5: ignored, result 15; then `start` 7 × 9 in the DONE cycle → 63 after 33 more cycles.
- `rst_n` low at ITER cycle 10 of 0x10000 × 0x10000: immediate IDLE with zero outputs; a following 2 × 2 returns 4 with normal latency.
- 0x80000000 × 2: `product_hi` = 0x00000001, `product_lo` = 0x00000000.
